rst_sequencer: RTL and testbench

//  Parametrised clock/reset manager controller that runs alongside the MMCM instance.
//  - Drives the MMCM reset and filters its LOCKED output.
//  - Releases NUM_CH downstream active-high domain resets in order, STAGE_DLY cycles apart.
//  - Re-asserts every domain reset on lock loss or soft request, then re-sequences.
//  - Runs on the free-running board clock, never on an MMCM output.

---
 rtl/clk_rst_pkg.sv | 22 ++
 rtl/bit_sync.sv | 26 ++
 rtl/rst_sequencer.sv | 177 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared types and sizing helpers for the clock/reset manager.
package clk_rst_pkg;

   // Sequencer states, in the order a clean power-up walks through them.
   typedef enum logic [2:0] {
      MMCM_RST  = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } rst_seq_state_e;

   // Bits needed to hold values 0..max_val; never returns less than 1.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchroniser for an asynchronous status input.
// Async active-low reset, both stages reset to 0.
module bit_sync (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to settle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: drives the MMCM reset, filters LOCKED and releases NUM_CH
// domain resets in ascending order, STAGE_DLY cycles apart.
// Optional lock-timeout watchdog: define RST_SEQ_WATCHDOG_EN.
// Clocked from the free-running board clock, never from an MMCM output.
module rst_sequencer
   import clk_rst_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int MMCM_RST_CYC = 8,
   parameter int LOCK_FILTER  = 16,
   parameter int STAGE_DLY    = 4,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int CNT_W        = 8
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              locked_i,
   input  logic              soft_rst_i,
   output logic              mmcm_rst_o,
   output logic [NUM_CH-1:0] rst_o,
   output logic              ready_o,
   output logic [CNT_W-1:0]  lock_loss_cnt_o,
   output logic              timeout_o
);

   // One cycle counter is shared by every timed state, so size it for the longest.
   localparam int CYC_MAX = max_int(max_int(MMCM_RST_CYC, LOCK_FILTER),
                                    max_int(STAGE_DLY, LOCK_TIMEOUT));
   localparam int CYC_W   = cnt_width(CYC_MAX);
   localparam int CH_W    = cnt_width(NUM_CH - 1);

   localparam logic [CYC_W-1:0] MMCM_LAST = CYC_W'(MMCM_RST_CYC - 1);
   localparam logic [CYC_W-1:0] FILT_LAST = CYC_W'(LOCK_FILTER - 1);
   localparam logic [CYC_W-1:0] STG_LAST  = CYC_W'(STAGE_DLY - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] LOSS_MAX  = '1;

   rst_seq_state_e    state_q;
   logic [CYC_W-1:0]  cyc_q;
   logic [CH_W-1:0]   ch_q;
   logic              mmcm_rst_q;
   logic [NUM_CH-1:0] rst_q;
   logic              ready_q;
   logic [CNT_W-1:0]  loss_q;

   logic              lk_s;
   logic              lock_loss_d;
   logic [CNT_W-1:0]  loss_d;

`ifdef RST_SEQ_WATCHDOG_EN
   localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT - 1);
   logic timeout_q;
`endif

   bit_sync u_lock_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (locked_i),
      .q_o    (lk_s)
   );

   // A drop only counts as lock loss once domains have started leaving reset;
   // earlier drops just restart the filter. The counter sticks at its maximum.
   always_comb begin
      lock_loss_d = !lk_s && ((state_q == RELEASE) || (state_q == RUN));
      loss_d      = (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
   end

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= MMCM_RST;
         cyc_q      <= '0;
         ch_q       <= '0;
         mmcm_rst_q <= 1'b1;
         rst_q      <= '1;
         ready_q    <= 1'b0;
         loss_q     <= '0;
`ifdef RST_SEQ_WATCHDOG_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
`ifdef RST_SEQ_WATCHDOG_EN
         timeout_q <= 1'b0;
`endif
         if (soft_rst_i || lock_loss_d) begin
            // Soft request wins over a simultaneous lock loss and is not counted.
            state_q    <= MMCM_RST;
            cyc_q      <= '0;
            ch_q       <= '0;
            mmcm_rst_q <= 1'b1;
            rst_q      <= '1;
            ready_q    <= 1'b0;
            if (!soft_rst_i) begin
               loss_q <= loss_d;
            end
         end else begin
            case (state_q)
               MMCM_RST: begin
                  if (cyc_q == MMCM_LAST) begin
                     state_q    <= WAIT_LOCK;
                     cyc_q      <= '0;
                     mmcm_rst_q <= 1'b0;
                  end else begin
                     cyc_q <= cyc_q + 1'b1;
                  end
               end
               WAIT_LOCK: begin
                  if (lk_s) begin
                     state_q <= FILTER;
                     cyc_q   <= '0;
                  end
`ifdef RST_SEQ_WATCHDOG_EN
                  else if (cyc_q == TMO_LAST) begin
                     state_q    <= MMCM_RST;
                     cyc_q      <= '0;
                     mmcm_rst_q <= 1'b1;
                     timeout_q  <= 1'b1;
                  end else begin
                     cyc_q <= cyc_q + 1'b1;
                  end
`endif
               end
               FILTER: begin
                  if (!lk_s) begin
                     state_q <= WAIT_LOCK;
                     cyc_q   <= '0;
                  end else if (cyc_q == FILT_LAST) begin
                     // Channel 0 leaves reset on the same edge we enter RELEASE.
                     state_q <= RELEASE;
                     cyc_q   <= '0;
                     ch_q    <= '0;
                     rst_q   <= rst_q << 1;
                  end else begin
                     cyc_q <= cyc_q + 1'b1;
                  end
               end
               RELEASE: begin
                  // Shifting zeros in from bit 0 guarantees ascending release order.
                  if (ch_q == CH_LAST) begin
                     state_q <= RUN;
                     ready_q <= 1'b1;
                  end else if (cyc_q == STG_LAST) begin
                     cyc_q <= '0;
                     ch_q  <= ch_q + 1'b1;
                     rst_q <= rst_q << 1;
                  end else begin
                     cyc_q <= cyc_q + 1'b1;
                  end
               end
               RUN: begin
                  ready_q <= 1'b1;
               end
               default: begin
                  state_q    <= MMCM_RST;
                  cyc_q      <= '0;
                  ch_q       <= '0;
                  mmcm_rst_q <= 1'b1;
                  rst_q      <= '1;
                  ready_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mmcm_rst_o      = mmcm_rst_q;
   assign rst_o           = rst_q;
   assign ready_o         = ready_q;
   assign lock_loss_cnt_o = loss_q;
`ifdef RST_SEQ_WATCHDOG_EN
   assign timeout_o       = timeout_q;
`else
   assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: randomized + directed stimulus, phase/time reference model,
// output-change scoreboard. Honours RST_SEQ_WATCHDOG_EN like the design.
module tb_rst_sequencer;

   localparam int NUM_CH       = 3;
   localparam int MMCM_RST_CYC = 8;
   localparam int LOCK_FILTER  = 16;
   localparam int STAGE_DLY    = 4;
   localparam int LOCK_TIMEOUT = 64;
   localparam int CNT_W        = 2;
   localparam int W            = 3 + NUM_CH + CNT_W;
`ifdef RST_SEQ_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn_i, locked_i, soft_rst_i;
   logic mmcm_rst_o, ready_o, timeout_o;
   logic [NUM_CH-1:0] rst_o;
   logic [CNT_W-1:0]  lock_loss_cnt_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rst_sequencer #(
      .NUM_CH(NUM_CH), .MMCM_RST_CYC(MMCM_RST_CYC), .LOCK_FILTER(LOCK_FILTER),
      .STAGE_DLY(STAGE_DLY), .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rstn_i(rstn_i), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
      .mmcm_rst_o(mmcm_rst_o), .rst_o(rst_o), .ready_o(ready_o),
      .lock_loss_cnt_o(lock_loss_cnt_o), .timeout_o(timeout_o)
   );

   logic [W-1:0] dut_vec;
   assign dut_vec = {timeout_o, ready_o, mmcm_rst_o, rst_o, lock_loss_cnt_o};

   // ---------------- reference model: phase + time since phase entry -------------
   typedef enum int {P_MMCM, P_WAIT, P_FILT, P_REL, P_RUN} ph_t;
   typedef struct { int cyc; logic [W-1:0] v; } exp_t;

   exp_t         sb_q[$];
   int           cyc = 0;
   ph_t          ph = P_MMCM;
   int           t0 = 0;
   int           losses = 0;
   bit           tmo = 1'b0;
   logic         lk_d1 = 1'b0, lk_d2 = 1'b0;
   logic [W-1:0] exp_prev;

   function automatic logic [W-1:0] model_out(input ph_t p, input int e, input int nl, input bit t);
      logic [NUM_CH-1:0] ones;
      logic [NUM_CH-1:0] r;
      int k;
      ones = '1;
      if (p == P_REL) begin
         k = e / STAGE_DLY + 1;
         if (k > NUM_CH) k = NUM_CH;
         r = ones << k;
      end else if (p == P_RUN) begin
         r = '0;
      end else begin
         r = ones;
      end
      return {t, (p == P_RUN), (p == P_MMCM), r, nl[CNT_W-1:0]};
   endfunction

   always @(posedge clk) begin
      logic lk;
      logic [W-1:0] v;
      int e;
      cyc = cyc + 1;
      if (!rstn_i) begin
         ph = P_MMCM; t0 = cyc; losses = 0; tmo = 1'b0; lk_d1 = 1'b0; lk_d2 = 1'b0;
         exp_prev = model_out(ph, 0, 0, 1'b0);
      end else begin
         lk = lk_d2; lk_d2 = lk_d1; lk_d1 = locked_i;   // two-cycle sync latency
         tmo = 1'b0;
         e = cyc - t0;
         if (soft_rst_i) begin
            ph = P_MMCM; t0 = cyc;
         end else if (!lk && (ph == P_REL || ph == P_RUN)) begin
            if (losses < (2 ** CNT_W) - 1) losses = losses + 1;
            ph = P_MMCM; t0 = cyc;
         end else begin
            case (ph)
               P_MMCM: if (e == MMCM_RST_CYC) begin ph = P_WAIT; t0 = cyc; end
               P_WAIT: begin
                  if (lk) begin ph = P_FILT; t0 = cyc; end
                  else if (WD && e == LOCK_TIMEOUT) begin tmo = 1'b1; ph = P_MMCM; t0 = cyc; end
               end
               P_FILT: begin
                  if (!lk) begin ph = P_WAIT; t0 = cyc; end
                  else if (e == LOCK_FILTER) begin ph = P_REL; t0 = cyc; end
               end
               P_REL: if (e == (NUM_CH - 1) * STAGE_DLY + 1) begin ph = P_RUN; t0 = cyc; end
               default: ;
            endcase
         end
         v = model_out(ph, cyc - t0, losses, tmo);
         if (v !== exp_prev) sb_q.push_back('{cyc, v});
         exp_prev = v;
      end
   end

   // ---------------- monitor: pops one expectation per DUT output change --------
   bit           mon_en = 1'b0;
   logic [W-1:0] dut_prev;

   always @(negedge clk) begin
      exp_t x;
      if (mon_en) begin
         if (dut_vec !== dut_prev) begin
            total = total + 1;
            if (sb_q.size() == 0) begin
               bad = bad + 1;
               $display("FAIL sb_unexpected: cyc=%0d got=%b, no change expected", cyc, dut_vec);
            end else begin
               x = sb_q.pop_front();
               if (x.cyc != cyc || x.v !== dut_vec) begin
                  bad = bad + 1;
                  $display("FAIL sb_txn: got=%b@%0d want=%b@%0d", dut_vec, cyc, x.v, x.cyc);
               end else begin
                  $display("txn cyc=%0d out=%b", cyc, dut_vec);
               end
            end
            dut_prev = dut_vec;
         end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            x = sb_q.pop_front();
            total = total + 1;
            bad = bad + 1;
            $display("FAIL sb_missing: got=%b@%0d want=%b@%0d", dut_vec, cyc, x.v, x.cyc);
         end
      end
   end

   // ---------------- directed helpers -------------------------------------------
   task automatic check(input string name, input int got, input int want);
      total = total + 1;
      if (got != want) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0d want=%0d", name, got, want);
      end else begin
         $display("check %s: %0d", name, got);
      end
   endtask

   task automatic wait_rst_low(input int k, output int at);
      int n = 0;
      while (rst_o[k] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
      at = cyc;
      if (n >= 1000) begin
         total = total + 1; bad = bad + 1;
         $display("FAIL wait_rst%0d: still %b after %0d cycles, want 0", k, rst_o[k], n);
      end
   endtask

   task automatic wait_ready(output int at);
      int n = 0;
      while (ready_o !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      at = cyc;
      if (n >= 1000) begin
         total = total + 1; bad = bad + 1;
         $display("FAIL wait_ready: ready=%b after %0d cycles, want 1", ready_o, n);
      end
   endtask

   task automatic soft_pulse();
      soft_rst_i = 1'b1;
      @(negedge clk);
      soft_rst_i = 1'b0;
   endtask

   task automatic mmcm_len(output int n);
      n = 0;
      while (mmcm_rst_o === 1'b1 && n < 100) begin n++; @(negedge clk); end
   endtask

   // ---------------- stimulus ---------------------------------------------------
   initial begin
      int n, t_rdy, pulses, viol;
      int t_clr[NUM_CH];
      rstn_i = 1'b0; locked_i = 1'b0; soft_rst_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", int'(dut_vec), int'({1'b0, 1'b0, 1'b1, {NUM_CH{1'b1}}, {CNT_W{1'b0}}}));
      rstn_i = 1'b1;
      dut_prev = dut_vec;
      mon_en = 1'b1;

      // 1: power-up, lock 20 cycles after reset release
      mmcm_len(n);
      check("t1_mmcm_len", n, MMCM_RST_CYC);
      repeat (20 - n) @(negedge clk);
      locked_i = 1'b1;
      for (int k = 0; k < NUM_CH; k++) wait_rst_low(k, t_clr[k]);
      for (int k = 1; k < NUM_CH; k++) check($sformatf("t1_gap%0d", k), t_clr[k] - t_clr[k-1], STAGE_DLY);
      wait_ready(t_rdy);
      check("t1_ready_lat", t_rdy - t_clr[NUM_CH-1], 1);

      // 2: short lock glitch inside FILTER
      locked_i = 1'b0;
      soft_pulse();
      n = 0;
      while (mmcm_rst_o === 1'b1 && n < 100) begin @(negedge clk); n++; end
      locked_i = 1'b1;
      repeat (5) @(negedge clk);
      locked_i = 1'b0;
      repeat (4) @(negedge clk);
      check("t2_rst_held", int'(rst_o), (1 << NUM_CH) - 1);
      check("t2_loss", int'(lock_loss_cnt_o), 0);
      locked_i = 1'b1;
      wait_ready(t_rdy);

      // 3: lock drop in RUN
      locked_i = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_rst_all", int'(rst_o), (1 << NUM_CH) - 1);
      check("t3_ready", int'(ready_o), 0);
      check("t3_loss", int'(lock_loss_cnt_o), 1);
      locked_i = 1'b1;
      wait_ready(t_rdy);

      // 5: soft request coinciding with a synced lock drop mid-RELEASE
      soft_pulse();
      wait_rst_low(0, n);
      locked_i = 1'b0;
      repeat (2) @(negedge clk);
      soft_pulse();
      mmcm_len(n);
      check("t5_mmcm_len", n, MMCM_RST_CYC);
      check("t5_loss", int'(lock_loss_cnt_o), 1);
      locked_i = 1'b1;
      wait_ready(t_rdy);

      // 4: repeated losses saturate the counter
      for (int i = 0; i < 5; i++) begin
         locked_i = 1'b0;
         repeat (6) @(negedge clk);
         locked_i = 1'b1;
         wait_ready(t_rdy);
      end
      check("t4_loss_sat", int'(lock_loss_cnt_o), (2 ** CNT_W) - 1);

      // 6: lock never returns
      locked_i = 1'b0;
      soft_pulse();
      pulses = 0; viol = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (timeout_o === 1'b1) pulses++;
         if (rst_o !== {NUM_CH{1'b1}}) viol++;
      end
      check("t6_pulses", pulses, WD ? 2 : 0);
      check("t6_rst_held", viol, 0);
      check("t6_wait_mmcm", int'(mmcm_rst_o), 0);

      // 7: random lock activity with occasional soft requests
      for (int s = 0; s < 40; s++) begin
         locked_i = 1'($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) == 0) soft_pulse();
         repeat (locked_i ? $urandom_range(1, 120) : $urandom_range(1, 30)) @(negedge clk);
      end
      locked_i = 1'b1;
      soft_rst_i = 1'b0;
      wait_ready(t_rdy);
      repeat (5) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time limit reached, want finish");
      $fatal(1, "timeout");
   end

endmodule
